apb_initiator: RTL

- APB3 requester that turns a simple valid/ready request/response channel into single APB transfers.
- Lets a core-side agent or debug path drive APB peripherals such as the RISC-V timer (16-bit `paddr`, 32-bit data) without handling SETUP/ACCESS phasing itself.
- One transfer in flight at a time.
- Optional access-phase timeout converts a hung slave into an error response.

---
 rtl/apb_initiator_pkg.sv | 14 +
 rtl/apb_initiator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apb_initiator_pkg.sv
// rtl/apb_initiator_pkg.sv - shared FSM encoding and APB response codes for apb_initiator
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - valid/ready request channel to single APB3 transfers
// One transfer in flight; optional ACCESS-phase timeout turns a hung slave into an error.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int W_ADDR         = 16,
  parameter int W_DATA         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int W_TOCNT        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [W_ADDR-1:0] paddr,
  output logic [W_DATA-1:0] pwdata,
  input  logic [W_DATA-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [W_TOCNT-1:0] TO_LAST = W_TOCNT'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic [W_ADDR-1:0]   paddr_q, paddr_d;
  logic [W_DATA-1:0]   pwdata_q, pwdata_d;
  logic [W_DATA-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [W_TOCNT-1:0]  cnt_q, cnt_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready has priority over a timeout landing on the same cycle
        if (pready) begin
          rsp_err_d     = (pslverr == APB_RESP_SLVERR);
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
          state_d       = ST_RESP;
        end else if (timeout_hit) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
